// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
//
// Two-requester front end for one shared, purely combinational ALU.
//   - The requester selected by the arbiter has its operands and opcode steered
//     to alu_x / alu_y / alu_ctrl.
//   - On the clock edge that ends a grant cycle, the ALU result, the granted
//     requester id and the condition flags go into a one-entry response
//     register. Latency is one cycle and the block can issue one op per cycle.
//   - While a response is held and not yet accepted, no new grant is issued.
//
// Opcodes: 0 add, 1 sub (a - b), 2 and, 3 xor.
//
// Build option:
//   ALU_SCHED_FIXED_PRIO_EN - when defined, req0 always wins contention and the
//                             last-granted pointer is not built. Without it,
//                             contention is resolved round-robin.
//
// Reset is synchronous and active-high.
// -----------------------------------------------------------------------------
module alu_sched #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,

    // Requester 0
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_op,

    // Requester 1
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_op,

    // Shared ALU
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [1:0]   alu_ctrl,
    input  logic [W-1:0] alu_res,
    input  logic         alu_carry,

    // Response
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_res,
    output logic         rsp_cf,
    output logic         rsp_zf,
    output logic         rsp_sf,
    output logic         rsp_of
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_e         state_q;
    state_e         state_d;

    logic           grant_ok;     // the response slot can take a new result
    logic           pick1;        // arbiter selects requester 1
    logic           grant;        // a transfer happens this cycle

    logic           flag_cf;
    logic           flag_zf;
    logic           flag_sf;
    logic           flag_of;

    logic           rsp_id_q;
    logic           rsp_id_d;
    logic [W-1:0]   rsp_res_q;
    logic [W-1:0]   rsp_res_d;
    logic           rsp_cf_q;
    logic           rsp_cf_d;
    logic           rsp_zf_q;
    logic           rsp_zf_d;
    logic           rsp_sf_q;
    logic           rsp_sf_d;
    logic           rsp_of_q;
    logic           rsp_of_d;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state - a grant always lands a result; an accepted response
    // with nothing new behind it drains the slot.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: a default assignment at the top of every combinational block
        // keeps each path assigned and prevents latch inference.
        state_d = state_q;
        if (grant) begin
            state_d = FULL;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs - slot availability and response-valid decode
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_valid = (state_q == FULL);
        // A new op may issue into an empty slot, or into a full slot whose
        // contents are being consumed this same cycle. Nothing issues in reset.
        grant_ok  = !rst && ((state_q == EMPTY) || rsp_ready);
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef ALU_SCHED_FIXED_PRIO_EN

    // Fixed priority: requester 1 wins only when requester 0 is idle
    always_comb begin
        pick1 = req1_valid && !req0_valid;
    end

`else

    // Last-granted pointer: 1 means requester 1 won the most recent grant.
    // Reset value 1 hands the first contention to requester 0.
    logic last_q;
    logic last_d;

    // Round-robin: under contention, the requester not granted last wins
    always_comb begin
        pick1 = req1_valid && (!req0_valid || !last_q);
    end

    // Pointer advances only when a transfer actually happens
    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = pick1;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // Handshake decode: at most one ready, only toward a valid requester
    always_comb begin
        req0_ready = grant_ok && req0_valid && !pick1;
        req1_ready = grant_ok && pick1;
        grant      = req0_ready || req1_ready;
    end

    // -------------------------------------------------------------------------
    // Shared ALU operand steering - requester 1 only while it is granted,
    // requester 0 otherwise (values outside a grant are don't-care downstream).
    // -------------------------------------------------------------------------
    always_comb begin
        alu_x    = req0_a;
        alu_y    = req0_b;
        alu_ctrl = req0_op;
        if (req1_ready) begin
            alu_x    = req1_a;
            alu_y    = req1_b;
            alu_ctrl = req1_op;
        end
    end

    // -------------------------------------------------------------------------
    // Condition flags from the ALU result and the operands it was given.
    // Carry comes straight from the ALU for arithmetic ops. Signed overflow is
    // detected from sign bits: add overflows when like-signed operands give a
    // result of the other sign; sub overflows when unlike-signed operands give
    // a result whose sign differs from the minuend.
    // -------------------------------------------------------------------------
    always_comb begin
        flag_zf = (alu_res == '0);
        flag_sf = alu_res[W-1];
        flag_cf = 1'b0;
        flag_of = 1'b0;
        unique case (alu_ctrl)
            OP_ADD: begin
                flag_cf = alu_carry;
                flag_of = (alu_x[W-1] == alu_y[W-1]) && (alu_res[W-1] != alu_x[W-1]);
            end
            OP_SUB: begin
                flag_cf = alu_carry;
                flag_of = (alu_x[W-1] != alu_y[W-1]) && (alu_res[W-1] != alu_x[W-1]);
            end
            OP_AND,
            OP_XOR: begin
                flag_cf = 1'b0;
                flag_of = 1'b0;
            end
            default: begin
                flag_cf = 1'b0;
                flag_of = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Response payload next-state: load on a grant, otherwise hold so the
    // outputs stay stable while the consumer stalls.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_id_d  = rsp_id_q;
        rsp_res_d = rsp_res_q;
        rsp_cf_d  = rsp_cf_q;
        rsp_zf_d  = rsp_zf_q;
        rsp_sf_d  = rsp_sf_q;
        rsp_of_d  = rsp_of_q;
        if (grant) begin
            rsp_id_d  = req1_ready;
            rsp_res_d = alu_res;
            rsp_cf_d  = flag_cf;
            rsp_zf_d  = flag_zf;
            rsp_sf_d  = flag_sf;
            rsp_of_d  = flag_of;
        end
    end

    // Response payload registers - cleared by reset so a discarded result
    // never leaks onto the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id_q  <= 1'b0;
            rsp_res_q <= '0;
            rsp_cf_q  <= 1'b0;
            rsp_zf_q  <= 1'b0;
            rsp_sf_q  <= 1'b0;
            rsp_of_q  <= 1'b0;
        end else begin
            rsp_id_q  <= rsp_id_d;
            rsp_res_q <= rsp_res_d;
            rsp_cf_q  <= rsp_cf_d;
            rsp_zf_q  <= rsp_zf_d;
            rsp_sf_q  <= rsp_sf_d;
            rsp_of_q  <= rsp_of_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output wiring
    // -------------------------------------------------------------------------
    assign rsp_id  = rsp_id_q;
    assign rsp_res = rsp_res_q;
    assign rsp_cf  = rsp_cf_q;
    assign rsp_zf  = rsp_zf_q;
    assign rsp_sf  = rsp_sf_q;
    assign rsp_of  = rsp_of_q;

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched - self-checking bench for alu_sched (W = 64).
// Provides a behavioural ALU on the shared-ALU port, drives directed scenarios
// followed by random traffic, and compares every cycle against a transaction
// level model (slot occupancy, arbitration winner, arithmetic result/flags).
// Honours ALU_SCHED_FIXED_PRIO_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_alu_sched;

    localparam int W = 64;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // DUT signals
    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] alu_x, alu_y, alu_res;
    logic [1:0]   alu_ctrl;
    logic         alu_carry;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_res;
    logic         rsp_cf, rsp_zf, rsp_sf, rsp_of;

    alu_sched #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctrl   (alu_ctrl),
        .alu_res    (alu_res),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_cf     (rsp_cf),
        .rsp_zf     (rsp_zf),
        .rsp_sf     (rsp_sf),
        .rsp_of     (rsp_of)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU: carry is carry-out for add, borrow for sub
    always_comb begin
        logic [W:0] wide;
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_ctrl)
            2'd0: begin
                wide      = {1'b0, alu_x} + {1'b0, alu_y};
                alu_res   = wide[W-1:0];
                alu_carry = wide[W];
            end
            2'd1: begin
                alu_res   = alu_x - alu_y;
                alu_carry = (alu_x < alu_y);
            end
            2'd2: alu_res = alu_x & alu_y;
            default: alu_res = alu_x ^ alu_y;
        endcase
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         cf, zf, sf, of;
    } rec_t;

    int   checks = 0;
    int   errors = 0;

    bit   m_full;   // a result is being held
    bit   m_clean;  // payload known to be all-zero since reset
    int   m_last;   // id of the last granted requester
    rec_t m_rec;

    // Expected result of one operation, computed with plain wide arithmetic
    function automatic rec_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] op, input logic id);
        rec_t        r;
        logic [W:0]  s;   // sign-extended signed result, one bit wider
        r    = '0;
        r.id = id;
        case (op)
            2'd0: begin
                r.res = a + b;
                r.cf  = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
                s     = {a[W-1], a} + {b[W-1], b};
                r.of  = (s[W] != s[W-1]);
            end
            2'd1: begin
                r.res = a - b;
                r.cf  = (a < b);
                s     = {a[W-1], a} - {b[W-1], b};
                r.of  = (s[W] != s[W-1]);
            end
            2'd2: r.res = a & b;
            default: r.res = a ^ b;
        endcase
        r.zf = (r.res == 0);
        r.sf = $signed(r.res) < 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [1:0] op0, input bit v1, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic [1:0] op1, input bit rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = rr;
    endtask

    // One clock cycle: inputs already driven at the falling edge. Checks all
    // outputs against the model, then advances the model across the edge.
    task automatic run_cycle();
        bit   ok;
        int   w;
        rec_t r;
        #1;
        ok = !rst && (!m_full || rsp_ready);
        w  = -1;
        if (ok && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) w = FIXED ? 0 : 1 - m_last;
            else                          w = req0_valid ? 0 : 1;
        end
        check("req0_ready", W'(req0_ready), W'(w == 0));
        check("req1_ready", W'(req1_ready), W'(w == 1));
        r = '0;
        if (w == 0) begin
            check("alu_x0", alu_x, req0_a);
            check("alu_y0", alu_y, req0_b);
            check("alu_ctrl0", W'(alu_ctrl), W'(req0_op));
            r = ref_op(req0_a, req0_b, req0_op, 1'b0);
        end else if (w == 1) begin
            check("alu_x1", alu_x, req1_a);
            check("alu_y1", alu_y, req1_b);
            check("alu_ctrl1", W'(alu_ctrl), W'(req1_op));
            r = ref_op(req1_a, req1_b, req1_op, 1'b1);
        end
        check("rsp_valid", W'(rsp_valid), W'(m_full));
        if (m_full || m_clean) begin
            check("rsp_id", W'(rsp_id), W'(m_rec.id));
            check("rsp_res", rsp_res, m_rec.res);
            check("rsp_cf", W'(rsp_cf), W'(m_rec.cf));
            check("rsp_zf", W'(rsp_zf), W'(m_rec.zf));
            check("rsp_sf", W'(rsp_sf), W'(m_rec.sf));
            check("rsp_of", W'(rsp_of), W'(m_rec.of));
        end
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_clean = 1; m_last = 1; m_rec = '0;
        end else if (w >= 0) begin
            m_full = 1; m_clean = 0; m_last = w; m_rec = r;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [3:0] exp_seq;
        m_full = 0; m_clean = 0; m_last = 1; m_rec = '0;
        rst = 1'b1;
        drive(0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 1'b0);
        @(negedge clk);

        // Reset: readies low, outputs cleared
        run_cycle();
        drive(1, 64'd1, 64'd2, 2'd0, 1, 64'd3, 64'd4, 2'd0, 1'b1);
        run_cycle();
        rst = 1'b0;

        // Single req0 xor 20^10 = 30, result one cycle later
        drive(1, 64'd20, 64'd10, 2'd3, 0, '0, '0, 2'd0, 1'b0);
        run_cycle();
        check("r035_valid", W'(rsp_valid), W'(1));
        check("r035_res", rsp_res, 64'd30);
        check("r035_id", W'(rsp_id), W'(0));
        check("r035_zf", W'(rsp_zf), W'(0));
        drive(0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 1'b1);
        run_cycle();

        // Fill the slot, stall, then reset while FULL
        drive(0, '0, '0, 2'd0, 1, 64'd9, 64'd4, 2'd1, 1'b0);
        run_cycle();
        drive(1, 64'd7, 64'd7, 2'd0, 1, 64'd8, 64'd8, 2'd0, 1'b0);
        rst = 1'b1;
        run_cycle();
        check("r039_valid", W'(rsp_valid), W'(0));
        check("r039_res", rsp_res, '0);
        check("r039_flags", W'({rsp_id, rsp_cf, rsp_zf, rsp_sf, rsp_of}), '0);
        rst = 1'b0;

        // Continuous contention, consumer always ready
        exp_seq = FIXED ? 4'b0000 : 4'b1010;  // bit i = expected id of result i
        drive(1, 64'd100, 64'd1, 2'd0, 1, 64'd200, 64'd2, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check("r036_id", W'(rsp_id), W'(exp_seq[i]));
            check("r036_valid", W'(rsp_valid), W'(1));
        end

        // req1 5-5 -> zero; then req0 max positive + 1 -> signed overflow
        drive(0, '0, '0, 2'd0, 1, 64'd5, 64'd5, 2'd1, 1'b1);
        run_cycle();
        check("r037_sub_res", rsp_res, '0);
        check("r037_sub_zf", W'(rsp_zf), W'(1));
        check("r037_sub_of", W'(rsp_of), W'(0));
        drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 0, '0, '0, 2'd0, 1'b1);
        run_cycle();
        check("r037_add_sf", W'(rsp_sf), W'(1));
        check("r037_add_of", W'(rsp_of), W'(1));

        // Stall 3 cycles with req0 waiting, then accept and grant together
        drive(1, 64'hF0F0, 64'h0FF0, 2'd2, 0, '0, '0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check("r038_hold_res", rsp_res, 64'h8000_0000_0000_0000);
        end
        rsp_ready = 1'b1;
        run_cycle();
        check("r038_next_res", rsp_res, 64'h00F0);
        drive(0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 1'b1);
        run_cycle();
        run_cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rand_operand(), rand_operand(),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, rand_operand(), rand_operand(),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: W, default 64, operand/result width; all data ports below are W bits wide.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  (N=0,1) grant; transfer occurs when reqN_valid && reqN_ready.
REQ-007 reqN_a, reqN_b  input  W  (N=0,1) operands.
REQ-008 reqN_op  input  2  (N=0,1) ALU control: 0 add, 1 sub (a-b), 2 and, 3 xor.
REQ-009 alu_x, alu_y  output  W  operands driven to the shared ALU instance.
REQ-010 alu_ctrl  output  2  control driven to the shared ALU.
REQ-011 alu_res  input  W; alu_carry  input  1  combinational ALU result and carry.
REQ-012 rsp_valid  output  1  registered result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_id  output  1  requester that issued the result.
REQ-015 rsp_res  output  W; rsp_cf, rsp_zf, rsp_sf, rsp_of  output  1 each  result and condition flags.

Function
REQ-016 The block SHALL have two states: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-017 A grant SHALL be possible in a cycle when state is EMPTY, or when state is FULL and rsp_ready=1.
REQ-018 When a grant is possible, at most one reqN_ready SHALL be 1, combinationally, and only for a requester with reqN_valid=1.
REQ-019 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; if one is valid, grant it.
REQ-020 During a grant cycle, alu_x/alu_y/alu_ctrl SHALL carry the granted requester's a/b/op; otherwise they SHALL carry req0's fields (don't-care to consumers).
REQ-021 On the edge ending a grant cycle, the block SHALL capture rsp_res=alu_res, rsp_id, and flags, and enter FULL; latency is 1 cycle and throughput is 1 op/cycle.
REQ-022 Flags: zf=(res==0); sf=res[W-1]; cf=alu_carry for ops 0/1, 0 for ops 2/3.
REQ-023 of for op 0 = (a[W-1]==b[W-1]) && (res[W-1]!=a[W-1]).
REQ-024 of for op 1 = (a[W-1]!=b[W-1]) && (res[W-1]!=a[W-1]).
REQ-025 of for ops 2/3 = 0.
REQ-026 In FULL with rsp_ready=0, all rsp_* outputs SHALL hold stable and both reqN_ready SHALL be 0.
REQ-027 In FULL with rsp_ready=1 and no valid requester, the next state SHALL be EMPTY.
REQ-028 Simultaneous accept of the response and a new grant SHALL replace the held result with no bubble.
REQ-029 Once asserted, reqN_valid/operands from a requester SHALL NOT be required to be held after transfer.

Reset
REQ-030 Reset SHALL set state EMPTY, rsp_valid=0, rsp_res=0, rsp_id=0, all flags 0.
REQ-031 Reset SHALL set the last-granted pointer to 1, so req0 wins the first contention.
REQ-032 Reset asserted mid-operation SHALL discard any held or in-flight result; reqN_ready SHALL be 0 while rst=1.

Configuration
REQ-033 Macro ALU_SCHED_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with req0 always winning contention and the last-granted pointer omitted.
REQ-034 Without the macro, arbitration SHALL be round-robin per REQ-019.

Verification
REQ-035 After reset, req0 valid with a=20, b=10, op=3 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_res=30, rsp_id=0, zf=0.
REQ-036 Both valid every cycle, rsp_ready=1 -> rsp_id sequence 0,1,0,1 (with macro: 0,0,0,0).
REQ-037 req1 a=5, b=5, op=1 -> rsp_res=0, zf=1, of=0; a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> sf=1, of=1.
REQ-038 Result held with rsp_ready=0 for 3 cycles while req0 valid -> req0_ready=0, rsp_* stable; rsp_ready=1 -> req0 granted same cycle, next result appears next cycle.
REQ-039 rst asserted while FULL -> next cycle rsp_valid=0 and all rsp_* zero; first post-reset contention grants req0.
